boundary_probe: RTL

BOUNDARY_PROBE -- requirements
Module: boundary_probe

---
 rtl/boundary_pkg.sv | 25 ++
 rtl/boundary_probe_if.sv | 36 +++
 rtl/probe_raster_cnt.sv | 56 +++++
 rtl/boundary_probe.sv | 127 ++++++++++++
 4 files changed

// File: rtl/boundary_pkg.sv
//------------------------------------------------------------------------------
// boundary_pkg : shared constants and FSM encoding for the boundary probe.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package boundary_pkg;

    localparam int SCREEN_W_DEF = 96;
    localparam int SCREEN_H_DEF = 64;
    localparam int MAP_LAT      = 1;
    localparam int COORD_W      = 8;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/boundary_probe_if.sv
//------------------------------------------------------------------------------
// boundary_probe_if : probe request/result and boundary-map query signals.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface boundary_probe_if
    import boundary_pkg::*;
    ;
    logic                 start;
    logic [COORD_W-2:0]   sx;
    logic [COORD_W-2:0]   sy;
    logic [CNT_W-1:0]     w_m1;
    logic [CNT_W-1:0]     h_m1;
    logic [COORD_W-2:0]   qx;
    logic [COORD_W-2:0]   qy;
    logic                 map_hit;
    logic                 busy;
    logic                 done;
    logic                 hit;
    logic [COORD_W-1:0]   hit_x;
    logic [COORD_W-1:0]   hit_y;

    modport slave (
        input  start, sx, sy, w_m1, h_m1, map_hit,
        output qx, qy, busy, done, hit, hit_x, hit_y
    );

    modport master (
        output start, sx, sy, w_m1, h_m1, map_hit,
        input  qx, qy, busy, done, hit, hit_x, hit_y
    );
endinterface

`default_nettype wire

// File: rtl/probe_raster_cnt.sv
//------------------------------------------------------------------------------
// probe_raster_cnt : raster i/j counter, i inner over 0..w_m1, j outer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module probe_raster_cnt
    import boundary_pkg::*;
(
    input  wire logic             clk50,
    input  wire logic             rst_n,
    input  wire logic             i_load,
    input  wire logic             i_step,
    input  wire logic [CNT_W-1:0] i_w_m1,
    input  wire logic [CNT_W-1:0] i_h_m1,
    output logic      [CNT_W-1:0] o_i,
    output logic      [CNT_W-1:0] o_j,
    output logic                  o_last
);
    logic [CNT_W-1:0] r_i;
    logic [CNT_W-1:0] r_j;
    logic [CNT_W-1:0] r_w;
    logic [CNT_W-1:0] r_h;
    logic             w_row_end;

    assign w_row_end = (r_i == r_w);

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_i <= '0;
            r_j <= '0;
            r_w <= '0;
            r_h <= '0;
        end else if (i_load) begin
            r_i <= '0;
            r_j <= '0;
            r_w <= i_w_m1;
            r_h <= i_h_m1;
        end else if (i_step && !o_last) begin
            if (w_row_end) begin
                r_i <= '0;
                r_j <= r_j + 1'b1;
            end else begin
                r_i <= r_i + 1'b1;
            end
        end
    end

    assign o_i    = r_i;
    assign o_j    = r_j;
    assign o_last = w_row_end && (r_j == r_h);

endmodule

`default_nettype wire

// File: rtl/boundary_probe.sv
//------------------------------------------------------------------------------
// boundary_probe : scans a sprite rectangle against the boundary map and the
// screen edges, reporting the first hit in raster order.
// Optional macro PROBE_EARLY_EXIT_EN: abort the scan on the first hit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module boundary_probe
    import boundary_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  wire logic        clk50,
    input  wire logic        rst_n,
    boundary_probe_if.slave  bus
);
    localparam logic [COORD_W:0] c_scr_w = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0] c_scr_h = (COORD_W+1)'(SCREEN_H);

    state_t               r_state;
    state_t               w_next;
    logic [COORD_W-2:0]   r_sx;
    logic [COORD_W-2:0]   r_sy;
    logic [COORD_W-1:0]   r_tag_x;
    logic [COORD_W-1:0]   r_tag_y;
    logic                 r_tag_vld;
    logic                 r_hit;
    logic [COORD_W-1:0]   r_hit_x;
    logic [COORD_W-1:0]   r_hit_y;

    logic [CNT_W-1:0]     w_i;
    logic [CNT_W-1:0]     w_j;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_scan;
    logic [COORD_W-1:0]   w_x;
    logic [COORD_W-1:0]   w_y;
    logic                 w_oob;
    logic                 w_resp_hit;

    assign w_accept = (r_state == ST_IDLE) && bus.start;
    assign w_scan   = (r_state == ST_SCAN);

    probe_raster_cnt u_cnt (
        .clk50  (clk50),
        .rst_n  (rst_n),
        .i_load (w_accept),
        .i_step (w_scan),
        .i_w_m1 (bus.w_m1),
        .i_h_m1 (bus.h_m1),
        .o_i    (w_i),
        .o_j    (w_j),
        .o_last (w_last)
    );

    // 8-bit sums so coordinates past column/row 127 are still seen as off-screen
    assign w_x = {1'b0, r_sx} + {{(COORD_W-CNT_W){1'b0}}, w_i};
    assign w_y = {1'b0, r_sy} + {{(COORD_W-CNT_W){1'b0}}, w_j};

    assign w_oob      = ({1'b0, r_tag_x} >= c_scr_w) || ({1'b0, r_tag_y} >= c_scr_h);
    assign w_resp_hit = r_tag_vld && (w_oob || bus.map_hit);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_next = ST_SCAN;
            ST_SCAN: begin
`ifdef PROBE_EARLY_EXIT_EN
                if (w_resp_hit)  w_next = ST_DONE;
                else if (w_last) w_next = ST_DRAIN;
`else
                if (w_last)      w_next = ST_DRAIN;
`endif
            end
            ST_DRAIN: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sx      <= '0;
            r_sy      <= '0;
            r_tag_x   <= '0;
            r_tag_y   <= '0;
            r_tag_vld <= 1'b0;
            r_hit     <= 1'b0;
            r_hit_x   <= '0;
            r_hit_y   <= '0;
        end else begin
            r_state   <= w_next;
            r_tag_vld <= w_scan;
            if (w_scan) begin
                r_tag_x <= w_x;
                r_tag_y <= w_y;
            end
            if (w_accept) begin
                r_sx    <= bus.sx;
                r_sy    <= bus.sy;
                r_hit   <= 1'b0;
                r_hit_x <= '0;
                r_hit_y <= '0;
            end else if (w_resp_hit && !r_hit) begin
                r_hit   <= 1'b1;
                r_hit_x <= r_tag_x;
                r_hit_y <= r_tag_y;
            end
        end
    end

    // Counters and origin only move on accept/scan, so qx/qy hold elsewhere
    assign bus.qx    = w_x[COORD_W-2:0];
    assign bus.qy    = w_y[COORD_W-2:0];
    assign bus.busy  = (r_state != ST_IDLE);
    assign bus.done  = (r_state == ST_DONE);
    assign bus.hit   = r_hit;
    assign bus.hit_x = r_hit_x;
    assign bus.hit_y = r_hit_y;

endmodule

`default_nettype wire
